decoder_3x8: RTL and testbench

- Registered 3-to-8 one-hot decoder.
- Three scalar select bits (a = MSB, b, c = LSB) drive an 8-bit one-hot output vector p, with an enable and an output-valid flag.
- Used as the address/partial-product select stage in the Vedic multiplier datapath.
- Output is registered: one clock of latency from input to output.

---
 rtl/decoder_3x8.sv | 83 ++++++++
 tb/tb_decoder_3x8.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/decoder_3x8.sv
// decoder_3x8: registered 3-to-8 one-hot decoder, one cycle of latency.
// Optional per-line saturating hit counters under `DECODER_3X8_HIT_CNT_EN.
module decoder_3x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       c,
`ifdef DECODER_3X8_HIT_CNT_EN
  input  logic [2:0] cnt_sel,
  input  logic       cnt_clr,
  output logic [7:0] cnt,
`endif
  output logic [0:7] p,
  output logic       valid
);

  logic [2:0] idx;
  logic [0:7] p_d, p_q;
  logic       valid_d, valid_q;

  assign idx = {a, b, c};

  always_comb begin
    p_d     = '0;
    valid_d = en;
    if (en) begin
      unique case (idx)
        3'd0: p_d = 8'b1000_0000;
        3'd1: p_d = 8'b0100_0000;
        3'd2: p_d = 8'b0010_0000;
        3'd3: p_d = 8'b0001_0000;
        3'd4: p_d = 8'b0000_1000;
        3'd5: p_d = 8'b0000_0100;
        3'd6: p_d = 8'b0000_0010;
        3'd7: p_d = 8'b0000_0001;
        default: p_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      p_q     <= p_d;
      valid_q <= valid_d;
    end
  end

  assign p     = p_q;
  assign valid = valid_q;

`ifdef DECODER_3X8_HIT_CNT_EN
  logic [7:0] cnt_q [8];
  logic [7:0] cnt_d [8];

  // Clear wins over increment; counters stick at 255.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (en && idx == 3'(i) && cnt_q[i] != 8'hff) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign cnt = cnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_decoder_3x8.sv
// tb_decoder_3x8: directed and randomized checks of decoder_3x8
// against an arithmetic reference model.
module tb_decoder_3x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       a, b, c;
  logic [0:7] p;
  logic       valid;
`ifdef DECODER_3X8_HIT_CNT_EN
  logic [2:0] cnt_sel;
  logic       cnt_clr;
  logic [7:0] cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  decoder_3x8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .a       (a),
    .b       (b),
    .c       (c),
`ifdef DECODER_3X8_HIT_CNT_EN
    .cnt_sel (cnt_sel),
    .cnt_clr (cnt_clr),
    .cnt     (cnt),
`endif
    .p       (p),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idx(input int i);
    {a, b, c} = 3'(i);
  endtask

  // Reference: line idx is the idx-th bit from the left.
  function automatic logic [7:0] ref_p(input logic e, input int i);
    return e ? 8'(128 >> i) : 8'd0;
  endfunction

  logic       r_en;
  int         r_idx;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    {a, b, c} = 3'b111;
`ifdef DECODER_3X8_HIT_CNT_EN
    cnt_sel = '0;
    cnt_clr = 1'b0;
`endif
    #1;
    chk("rst_p0", 32'(p), 32'd0);
    chk("rst_v0", 32'(valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_p", 32'(p), 32'd0);
      chk("rst_v", 32'(valid), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("rel_p", 32'(p), 32'h01);
    chk("rel_v", 32'(valid), 32'd1);

    for (int i = 0; i < 8; i++) begin
      set_idx(i);
      tick();
      chk("sweep_p", 32'(p), 32'(ref_p(1'b1, i)));
      chk("sweep_v", 32'(valid), 32'd1);
    end

    set_idx(5);
    en = 1'b1; tick();
    chk("en1_p", 32'(p), 32'h04);
    chk("en1_v", 32'(valid), 32'd1);
    en = 1'b0; tick();
    chk("en0_p", 32'(p), 32'h00);
    chk("en0_v", 32'(valid), 32'd0);
    en = 1'b1; tick();
    chk("en1b_p", 32'(p), 32'h04);
    chk("en1b_v", 32'(valid), 32'd1);

    set_idx(2);
    tick();
    chk("pre_rst_p", 32'(p), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_p", 32'(p), 32'd0);
    chk("async_v", 32'(valid), 32'd0);
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 1000; k++) begin
      r_en  = 1'($urandom_range(0, 1));
      r_idx = int'($urandom_range(0, 7));
      en = r_en;
      set_idx(r_idx);
      tick();
      chk("onehot", 32'($countones(p)), 32'(valid));
      chk("rand_p", 32'(p), 32'(ref_p(r_en, r_idx)));
      chk("rand_v", 32'(valid), 32'(r_en));
    end

`ifdef DECODER_3X8_HIT_CNT_EN
    cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    en = 1'b1;
    set_idx(3);
    for (int k = 0; k < 300; k++) tick();
    en = 1'b0;
    cnt_sel = 3'd3; #1;
    chk("cnt_sat", 32'(cnt), 32'((300 > 255) ? 255 : 300));
    cnt_sel = 3'd2; #1;
    chk("cnt_other", 32'(cnt), 32'd0);
    cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s); #1;
      chk("cnt_clr", 32'(cnt), 32'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
